// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: multi-channel PWM generator with one shared period counter
// and double-buffered period/duty registers. New settings are applied only at a
// period boundary, so the outputs never glitch.
//
// Ports:
//   clk_i            clock, all logic on the rising edge
//   rst_ni           asynchronous active-low reset, released synchronously
//   period_i         requested terminal count P
//   duty_cycle_i     requested duties, channel i at [i*WIDTH +: WIDTH]
//   load_i           one-cycle strobe that captures period_i/duty_cycle_i into staging
//   ch_en_i          per-channel enable; takes effect on the next cycle
//   center_mode_i    centre-aligned counting, sampled at each terminal count
//                    (present only when PWM_CENTER_ALIGN_EN is defined)
//   pwm_out_o        registered PWM outputs
//   period_start_o   one-cycle pulse aligned with the output for count 0
//   update_done_o    one-cycle pulse after staging is copied into the active registers
//
// Build option: define PWM_CENTER_ALIGN_EN to add centre-aligned (up/down) counting.
module pwm_multi_channel #(
    parameter int WIDTH        = 10,
    parameter int CHANNELS     = 4,
    parameter int RESET_PERIOD = 1023
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [CHANNELS*WIDTH-1:0] duty_cycle_i,
    input  logic                      load_i,
    input  logic [CHANNELS-1:0]       ch_en_i,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                      center_mode_i,
`endif
    output logic [CHANNELS-1:0]       pwm_out_o,
    output logic                      period_start_o,
    output logic                      update_done_o
);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]          period_q, stg_period_q;
    logic [CHANNELS*WIDTH-1:0] duty_q, stg_duty_q;
    logic                      pending_q;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      start_q, upd_q;
    logic                      tc;

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_q, dir_d, center_q, center_d;
    logic at_top;

    // Periods of 0 or 1 have no down leg: the top of the count is also the terminal count.
    always_comb begin
        at_top   = cnt_q == period_q;
        tc       = center_q ? ((dir_q && cnt_q == WIDTH'(1)) || (!dir_q && at_top && period_q <= WIDTH'(1)))
                            : at_top;
        cnt_d    = tc ? '0 : (center_q && (dir_q || at_top)) ? cnt_q - 1'b1 : cnt_q + 1'b1;
        dir_d    = tc ? 1'b0 : (center_q && at_top) ? 1'b1 : dir_q;
        center_d = tc ? center_mode_i : center_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q    <= 1'b0;
            center_q <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            center_q <= center_d;
        end
    end
`else
    always_comb begin
        tc    = cnt_q == period_q;
        cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
`endif

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CHANNELS; i++)
            pwm_d[i] = ch_en_i[i] && (cnt_q < duty_q[i*WIDTH +: WIDTH]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            period_q     <= WIDTH'(RESET_PERIOD);
            duty_q       <= '0;
            stg_period_q <= '0;
            stg_duty_q   <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            start_q      <= 1'b0;
            upd_q        <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            start_q <= cnt_q == '0;
            upd_q   <= tc && pending_q;
            // The transfer uses the staging value held before this edge, so a
            // LOAD on the TC cycle stays pending for the following TC.
            if (tc && pending_q) begin
                period_q <= stg_period_q;
                duty_q   <= stg_duty_q;
            end
            if (load_i) begin
                stg_period_q <= period_i;
                stg_duty_q   <= duty_cycle_i;
                pending_q    <= 1'b1;
            end else if (tc) begin
                pending_q    <= 1'b0;
            end
        end
    end

    assign pwm_out_o      = pwm_q;
    assign period_start_o = start_q;
    assign update_done_o  = upd_q;

endmodule
